// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider
// ----------------------------------------------------------------------------
// Multi-cycle restoring shift-subtract integer divider. It produces one
// quotient bit per cycle and uses a Start/Busy/Done handshake. Both unsigned
// and two's-complement operands are supported.
//
// Ports
//   i_clk          : clock. All state changes happen on the rising edge.
//   i_rst_n        : asynchronous active-low reset. It aborts any operation
//                    in progress.
//   i_start        : request. It is sampled only in IDLE.
//   i_signed       : 1 = two's-complement operands. Sampled with i_start.
//   i_dividend     : numerator. Sampled with i_start.
//   i_divisor      : denominator. Sampled with i_start.
//   o_busy         : high from the accepting edge until the DONE state.
//   o_done         : one-cycle pulse when the results are valid.
//   o_quotient     : registered quotient. It changes only at the FIX edge.
//   o_remainder    : registered remainder. It changes only at the FIX edge.
//   o_div_by_zero  : registered divide-by-zero flag. Valid with o_done.
//
// Timing: i_start sampled at edge N gives o_done high during the cycle after
// edge N+WIDTH+2. This latency is the same for every operand value.
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 24,
    parameter int CNTW  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operation context captured when a request is accepted.
    logic             r_neg_q;          // signed and the operand signs differ
    logic             r_neg_r;          // signed and the dividend is negative
    logic             r_dbz;            // divisor was zero
    logic [WIDTH-1:0] r_orig_dividend;  // returned unmodified on divide-by-zero
    logic [WIDTH-1:0] r_dvs;            // divisor magnitude

    // Iteration state.
    logic [WIDTH-1:0] r_rem;            // partial remainder
    logic [WIDTH-1:0] r_dvd;            // working dividend; quotient shifts in at LSB
    logic [CNTW-1:0]  r_count;

    // Output registers.
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_neg;
    logic [WIDTH-1:0] w_q_fixed;
    logic [WIDTH-1:0] w_r_fixed;

    // Operand magnitudes. The most-negative value negates to itself. As an
    // unsigned number that is exactly 2^(WIDTH-1), so it needs no special case.
    assign w_dvd_neg = i_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_signed & i_divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_abs = w_dvs_neg ? -i_divisor  : i_divisor;

    // The partial remainder is always below the divisor. That keeps the true
    // trial value in (-divisor, divisor), so a WIDTH+1 bit result is enough
    // and its MSB is the sign. With a zero divisor this reasoning fails, but
    // FIX then overrides both results.
    assign w_shift     = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_dvs};
    assign w_trial_neg = w_trial[WIDTH];

    assign w_q_fixed = r_neg_q ? -r_dvd : r_dvd;
    assign w_r_fixed = r_neg_r ? -r_rem : r_rem;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN) || (w_next == S_FIX);
            r_done  <= (w_next == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // RUN spends one extra cycle at a zero count before it moves to FIX.
    // That cycle fixes the total latency at WIDTH+2 edges from the accepting
    // edge to DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN:  if (r_count == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            r_dbz           <= 1'b0;
            r_orig_dividend <= '0;
            r_dvs           <= '0;
            r_rem           <= '0;
            r_dvd           <= '0;
            r_count         <= '0;
            r_quotient      <= '0;
            r_remainder     <= '0;
            r_div_by_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_neg_q         <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r         <= w_dvd_neg;
                        r_dbz           <= (i_divisor == '0);
                        r_orig_dividend <= i_dividend;
                        r_dvs           <= w_dvs_abs;
                        r_dvd           <= w_dvd_abs;
                        r_rem           <= '0;
                        r_count         <= CNTW'(WIDTH);
                    end
                end
                S_RUN: begin
                    if (r_count != '0) begin
                        if (w_trial_neg) begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                        end else begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_dvd <= {r_dvd[WIDTH-2:0], 1'b1};
                        end
                        r_count <= r_count - CNTW'(1);
                    end
                end
                S_FIX: begin
                    if (r_dbz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_orig_dividend;
                    end else begin
                        r_quotient  <= w_q_fixed;
                        r_remainder <= w_r_fixed;
                    end
                    r_div_by_zero <= r_dbz;
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider
// ----------------------------------------------------------------------------
// Self-checking bench for seq_divider (WIDTH=24).
//   - Table of directed vectors with fixed expected results.
//   - Hand-written sequences: Start while busy or in DONE, and reset in the
//     middle of an operation.
//   - Randomized back-to-back operations checked against an arithmetic
//     reference model.
// ============================================================================
module tb_seq_divider;

    localparam int W   = 24;
    localparam int LAT = 26;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sgn;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          dbz;

    int checks;
    int errors;

    seq_divider #(.WIDTH(W), .CNTW(5)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_signed      (sgn),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model built from the arithmetic definition of the operation.
    function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return {{W{1'b1}}, a, 1'b1};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {q[W-1:0], r[W-1:0], 1'b0};
    endfunction

    // Issues one request and waits for Done with a cycle budget.
    // lat counts the rising edges after the accepting edge up to the first
    // sample where Done is seen. The task ends one edge after Done, so the
    // next call issues its Start in the IDLE cycle right after DONE.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        logic [W-1:0] prev_q;
        int n;
        int ndone;
        bit held;
        bit overlap;
        prev_q = quotient;
        @(negedge clk);
        start = 1'b1; sgn = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs may change freely while the operation runs.
        sgn = 1'($urandom); dividend = W'($urandom); divisor = W'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        n = 0; ndone = 0; held = 1'b1; overlap = 1'b0;
        while (!done && n < LAT + 10) begin
            @(posedge clk); #1;
            n++;
            if (n < LAT - 1 && quotient !== prev_q) held = 1'b0;
            if (done && busy) overlap = 1'b1;
        end
        lat = n;
        q = quotient; r = remainder; z = dbz;
        check("quotient_held_while_busy", 64'(held), 64'd1);
        check("done_busy_overlap", 64'(overlap), 64'd0);
        @(posedge clk); #1;
        check("done_single_pulse", 64'(done), 64'd0);
    endtask

    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    logic [2*W:0] exp_m;
    int           ndone;

    initial begin
        checks = 0; errors = 0;
        start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;

        tbl[0] = '{1'b0, 24'd100,    24'd7,      24'h00000E, 24'h000002, 1'b0};
        tbl[1] = '{1'b1, 24'hFFFF9C, 24'd7,      24'hFFFFF2, 24'hFFFFFE, 1'b0};
        tbl[2] = '{1'b1, 24'd100,    24'hFFFFF9, 24'hFFFFF2, 24'h000002, 1'b0};
        tbl[3] = '{1'b1, 24'h800000, 24'hFFFFFF, 24'h800000, 24'h000000, 1'b0};
        tbl[4] = '{1'b0, 24'hFFFFFF, 24'd1,      24'hFFFFFF, 24'h000000, 1'b0};
        tbl[5] = '{1'b1, 24'h0004D2, 24'd0,      24'hFFFFFF, 24'h0004D2, 1'b1};
        tbl[6] = '{1'b0, 24'h0004D2, 24'd0,      24'hFFFFFF, 24'h0004D2, 1'b1};
        tbl[7] = '{1'b1, 24'h800000, 24'd1,      24'h800000, 24'h000000, 1'b0};

        // Reset state
        rst_n = 1'b0;
        #12;
        check("reset_outputs", {14'd0, busy, done, dbz, quotient, remainder}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, q, r, z, lat);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("tbl%0d_quotient", i), 64'(q), 64'(tbl[i].q));
            check($sformatf("tbl%0d_remainder", i), 64'(r), 64'(tbl[i].r));
            check($sformatf("tbl%0d_dbz", i), 64'(z), 64'(tbl[i].z));
        end

        // Start while busy (cycle 5) and in DONE (cycle 26) is ignored
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dividend = 24'd100; divisor = 24'd7;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (k == 4 || k == 26) begin
                start = 1'b1; sgn = 1'b1; dividend = 24'd999; divisor = 24'd5;
            end
            if (k == 5 || k == 27) start = 1'b0;
            if (k == 26) check("ignore_done_at_26", 64'(done), 64'd1);
            if (k == 28) check("ignore_idle_after", 64'(busy), 64'd0);
        end
        check("ignore_done_count", 64'(ndone), 64'd1);
        check("ignore_quotient", 64'(quotient), 64'h00000E);
        check("ignore_remainder", 64'(remainder), 64'h000002);

        // Reset during the operation, at cycle 10
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dividend = 24'd100; divisor = 24'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {14'd0, busy, done, dbz, quotient, remainder}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'd0);
        run_op(1'b0, 24'd9, 24'd3, q, r, z, lat);
        check("after_reset_latency", 64'(lat), 64'(LAT));
        check("after_reset_quotient", 64'(q), 64'd3);
        check("after_reset_remainder", 64'(r), 64'd0);

        // Random back-to-back operations against the model
        for (int i = 0; i < 60; i++) begin
            logic         rs;
            logic [W-1:0] ra, rb;
            rs = 1'($urandom);
            ra = W'($urandom);
            case ($urandom_range(0, 4))
                0: rb = W'($urandom_range(0, 15));
                1: rb = 24'hFFFFFF;
                2: rb = W'($urandom_range(0, 4095));
                default: rb = W'($urandom);
            endcase
            if (i % 11 == 0) ra = 24'h800000;
            exp_m = model(rs, ra, rb);
            run_op(rs, ra, rb, q, r, z, lat);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_result s=%0d a=%h b=%h", i, rs, ra, rb),
                  64'({q, r, z}), 64'(exp_m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
